// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - state encoding, default parameters and challenge pair decode for ro_puf_controller
package ro_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_COMPARE,
        ST_RESP
    } state_t;

    localparam int DEF_NUM_RO    = 16;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_WINDOW    = 1024;
    localparam int DEF_SETTLE    = 8;
    localparam int DEF_RESP_BITS = 8;
    localparam int DEF_MARGIN    = 4;

    localparam int MAX_IDX_W = 16;
    localparam int MAX_CH_W  = 1024;

    // Oscillator index of bit k, side A (side_b = 0) or side B (side_b = 1).
    function automatic logic [MAX_IDX_W-1:0] pair_sel(input logic [MAX_CH_W-1:0] ch,
                                                      input int idx_w, input int k,
                                                      input logic side_b);
        logic [MAX_CH_W-1:0] sh;
        sh = ch >> ((2 * k + int'(side_b)) * idx_w);
        return sh[MAX_IDX_W-1:0] & ((MAX_IDX_W'(1) << idx_w) - MAX_IDX_W'(1));
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - one measurement channel: oscillator mux, 2-flop synchronizer,
// rising-edge detect and saturating edge counter
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO = DEF_NUM_RO,
    parameter int IDX_W  = $clog2(NUM_RO),
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  sel,
    input  logic [NUM_RO-1:0] ro_out,
    input  logic              clear,
    input  logic              count_en,
    output logic [CNT_W-1:0]  count
);

    logic       mux_out;
    logic [2:0] sync_q;   // [0],[1] synchronizer, [2] edge reference

    assign mux_out = ro_out[sel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            count  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], mux_out};
            if (clear)
                count <= '0;
            else if (count_en && sync_q[1] && !sync_q[2] && (count != '1))
                count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ro_puf_controller.sv
// rtl/ro_puf_controller.sv - ring-oscillator PUF sequencer, one response bit per oscillator pair;
// RO_PUF_MARGIN_EN adds the per-bit instability flag
module ro_puf_controller
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO    = DEF_NUM_RO,
    parameter int IDX_W     = $clog2(NUM_RO),
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int RESP_BITS = DEF_RESP_BITS,
    parameter int MARGIN    = DEF_MARGIN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [RESP_BITS*2*IDX_W-1:0] challenge,
    output logic [NUM_RO-1:0]            ro_en,
    input  logic [NUM_RO-1:0]            ro_out,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [RESP_BITS-1:0]         response,
    output logic [RESP_BITS-1:0]         unstable
);

    localparam int CH_W  = RESP_BITS * 2 * IDX_W;
    localparam int K_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int TMR_W = $clog2((WINDOW > SETTLE) ? WINDOW : SETTLE) + 1;

    state_t              state;
    logic [CH_W-1:0]     chal_q;
    logic [K_W-1:0]      k_q;
    logic [K_W-1:0]      nxt_k;
    logic [TMR_W-1:0]    tmr;
    logic [IDX_W-1:0]    a_q, b_q, nxt_a, nxt_b;
    logic [NUM_RO-1:0]   nxt_mask;
    logic [MAX_CH_W-1:0] ch_ext;
    logic [CNT_W-1:0]    cnt_a, cnt_b;
    logic                last_bit;

    // Pair for the next SETTLE: bit 0 straight from the port at acceptance, else bit k+1.
    always_comb begin
        ch_ext = MAX_CH_W'(chal_q);
        nxt_k  = k_q + K_W'(1);
        if (state == ST_IDLE) begin
            ch_ext = MAX_CH_W'(challenge);
            nxt_k  = '0;
        end
        nxt_a    = IDX_W'(pair_sel(ch_ext, IDX_W, int'(nxt_k), 1'b0));
        nxt_b    = IDX_W'(pair_sel(ch_ext, IDX_W, int'(nxt_k), 1'b1));
        nxt_mask = (NUM_RO'(1) << nxt_a) | (NUM_RO'(1) << nxt_b);
    end

    assign last_bit = (k_q == K_W'(RESP_BITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            chal_q     <= '0;
            k_q        <= '0;
            tmr        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ro_en      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            response   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        chal_q    <= challenge;
                        k_q       <= '0;
                        a_q       <= nxt_a;
                        b_q       <= nxt_b;
                        ro_en     <= nxt_mask;
                        tmr       <= TMR_W'(SETTLE - 1);
                        response  <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr == '0) begin
                        tmr   <= TMR_W'(WINDOW - 1);
                        state <= ST_COUNT;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (tmr == '0) begin
                        ro_en <= '0;
                        state <= ST_COMPARE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_COMPARE: begin
                    response[k_q] <= (cnt_a > cnt_b);
                    if (last_bit) begin
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        k_q   <= nxt_k;
                        a_q   <= nxt_a;
                        b_q   <= nxt_b;
                        ro_en <= nxt_mask;
                        tmr   <= TMR_W'(SETTLE - 1);
                        state <= ST_SETTLE;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ro_edge_counter #(.NUM_RO(NUM_RO), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_chan_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (a_q),
        .ro_out   (ro_out),
        .clear    (state == ST_SETTLE),
        .count_en (state == ST_COUNT),
        .count    (cnt_a)
    );

    ro_edge_counter #(.NUM_RO(NUM_RO), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_chan_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (b_q),
        .ro_out   (ro_out),
        .clear    (state == ST_SETTLE),
        .count_en (state == ST_COUNT),
        .count    (cnt_b)
    );

`ifdef RO_PUF_MARGIN_EN
    logic [CNT_W-1:0] diff;

    assign diff = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);

    always_ff @(posedge clk) begin
        if (!rst_n)
            unstable <= '0;
        else if ((state == ST_IDLE) && req_valid)
            unstable <= '0;
        else if (state == ST_COMPARE)
            unstable[k_q] <= (diff < CNT_W'(MARGIN));
    end
`else
    logic unused_margin;

    assign unused_margin = ^MARGIN;
    assign unstable      = '0;
`endif

endmodule

// File: doc/ro_puf_controller.md
# ro_puf_controller

Sequencer for the ring-oscillator PUF array. Per request it measures RESP_BITS challenge-selected oscillator pairs: enables each pair, counts both oscillators' rising edges over a fixed window, and emits one response bit per pair. It sits between the challenge/response interface and the bank of `ring_oscillator` instances, driving their `en` inputs and sampling their `out` outputs.

## Interface
Parameters:
- NUM_RO, 16 — oscillators in the array; power of two, ≥ 2.
- IDX_W, $clog2(NUM_RO) — oscillator index width.
- CNT_W, 16 — edge-counter width.
- WINDOW, 1024 — counting window, clk cycles; 1 .. 2^CNT_W.
- SETTLE, 8 — cycles the pair is enabled before counting starts; ≥ 3.
- RESP_BITS, 8 — response bits per request.
- MARGIN, 4 — instability threshold, counts (used only under RO_PUF_MARGIN_EN).

Ports:
- clk  in  1 — the single clock.
- rst_n  in  1 — synchronous, active-low reset.
- req_valid  in  1 — a challenge is offered.
- req_ready  out  1 — controller can accept a challenge.
- challenge  in  RESP_BITS*2*IDX_W — bit k pair: A = challenge[2k*IDX_W +: IDX_W], B = the next IDX_W bits.
- ro_en  out  NUM_RO — enable for each oscillator.
- ro_out  in  NUM_RO — asynchronous oscillator outputs.
- resp_valid  out  1 — response held valid.
- resp_ready  in  1 — consumer accepts the response.
- response  out  RESP_BITS — bit k = 1 iff count(A_k) > count(B_k).
- unstable  out  RESP_BITS — bit k = 1 iff |count(A_k) − count(B_k)| < MARGIN.

## Operation
- States: IDLE, SETTLE, COUNT, COMPARE, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, latch challenge, set bit index k = 0, and go to SETTLE.
- SETTLE:
  - ro_en[A_k] = ro_en[B_k] = 1.
  - Per-channel input mux selects ro_out[A_k] / ro_out[B_k].
  - Counters are held at 0 while the synchronizers flush.
  - After SETTLE cycles, go to COUNT.
- COUNT:
  - Each channel passes its selected ro_out through a 2-flop synchronizer plus an edge flop.
  - Every detected rising edge increments that channel's counter.
  - Counters saturate at 2^CNT_W−1.
  - After WINDOW cycles, go to COMPARE. Counting stops exactly at the window end.
- COMPARE (1 cycle):
  - ro_en is all 0.
  - Write response[k] with a strict unsigned comparison; a tie gives 0.
  - Write unstable[k].
  - If k = RESP_BITS−1, go to RESP. Otherwise k++ and go to SETTLE.
- RESP:
  - resp_valid = 1; response and unstable are held stable.
  - When resp_ready is high, go to IDLE.
- A_k = B_k is legal: ro_en has a single bit set, counts are equal, response[k] = 0.
- ro_en has at most two bits set at any time, and bits are set only in SETTLE/COUNT.
- The counted oscillator frequency must be below clk/4; higher frequencies alias. This is a system requirement, not checked by the block.

## Timing
- Reset values: all state goes to IDLE and counters to 0.
  - req_ready = 1.
  - resp_valid = 0.
  - ro_en = 0.
  - response = 0.
  - unstable = 0.
- Reset mid-measurement: ro_en clears on the same edge; the partial response is discarded.
- Acceptance:
  - The accept cycle is the first cycle with req_valid && req_ready.
  - SETTLE starts the next cycle, and ro_en is visible then.
- Latency:
  - Per bit: SETTLE + WINDOW + 1 cycles.
  - resp_valid rises RESP_BITS*(SETTLE+WINDOW+1) cycles after the accept cycle.
- req_ready is 0 from the cycle after acceptance until RESP completes.
  - It returns to 1 the cycle after the resp_valid && resp_ready handshake.
  - There is no back-to-back acceptance on the handshake cycle.
- The challenge is registered at acceptance; later changes on the port are ignored.
- response bits not yet measured read 0 during a request and are cleared at acceptance.

## Configuration
- RO_PUF_MARGIN_EN defined:
  - An absolute-difference unit computes unstable[k] in COMPARE.
  - MARGIN = 0 gives all-zero unstable.
- RO_PUF_MARGIN_EN undefined:
  - unstable is tied to 0.
  - The subtractor and comparator are not synthesized.
  - The MARGIN parameter is ignored.

## Structure
- Package `ro_puf_pkg`:
  - State enum.
  - Default-parameter constants.
  - A `pair_sel` function that extracts A_k/B_k from the challenge.
- Sub-module `ro_edge_counter`, instantiated twice (channel A and channel B).
  - Contains: NUM_RO:1 mux, 2-flop synchronizer, edge detector, saturating CNT_W counter.
  - Controls: clear and count-enable.

## Test plan
- Bench ROs are behavioural toggles with per-index period. Test parameters: NUM_RO=4, WINDOW=64, SETTLE=4, RESP_BITS=2, MARGIN=4.
- RO0 period 10 clk, RO1 period 12 clk; challenge pairs (0,1),(1,0) -> response = 2'b01, resp_valid rises exactly 2*(4+64+1) = 138 cycles after accept.
- Pair (2,2) -> response bit 0; with RO_PUF_MARGIN_EN, unstable bit 1; without it, unstable = 0.
- RO0 period 10, RO3 period 11 (counts differ by < 4), pairs (0,3),(3,0) -> response 2'b01; unstable 2'b11 with the macro.
- Hold resp_ready = 0 for 20 cycles -> resp_valid, response, and unstable stay stable; req_ready stays 0; a new req_valid is not accepted until after the handshake.
- Assert rst_n = 0 during COUNT of bit 1 -> next cycle: ro_en = 0, req_ready = 1, resp_valid = 0; a fresh request then completes normally.
- Across all tests, assert popcount(ro_en) ≤ 2 and ro_en = 0 in IDLE/COMPARE/RESP.
